// File: rtl/kaipokrandt_ir_pkg.sv
// Shared constants, opcode encoding and helpers for the instruction queue.
// Optional same-cycle bypass is enabled by KAIPOKRANDT_IR_QUEUE_BYPASS_EN (see top).
package kaipokrandt_ir_pkg;

  localparam int IR_W_DEF  = 16;
  localparam int OPC_W_DEF = 4;
  localparam int P_W_DEF   = 6;

  // Default field layout must tile the instruction word exactly.
  localparam bit WIDTHS_OK = ((OPC_W_DEF + 2 * P_W_DEF) == IR_W_DEF);

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_XOR   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_CMP   = 4'hA,
    OP_JMP   = 4'hB,
    OP_JZ    = 4'hC,
    OP_CALL  = 4'hD,
    OP_RET   = 4'hE,
    OP_HALT  = 4'hF
  } opcode_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/kaipokrandt_ir_fields.sv
// Combinational split of an instruction word into opcode | param1 | param2.
// All outputs are forced to zero when the word is not valid.
module kaipokrandt_ir_fields
  import kaipokrandt_ir_pkg::*;
#(
  parameter int IR_W  = IR_W_DEF,
  parameter int OPC_W = OPC_W_DEF,
  parameter int P_W   = P_W_DEF
) (
  input  logic             valid,
  input  logic [IR_W-1:0]  word,
  output logic [IR_W-1:0]  ir_out,
  output logic [OPC_W-1:0] opcode,
  output logic [P_W-1:0]   param1,
  output logic [P_W-1:0]   param2
);

  assign ir_out = valid ? word : '0;
  assign opcode = ir_out[IR_W-1 -: OPC_W];
  assign param1 = ir_out[2*P_W-1 -: P_W];
  assign param2 = ir_out[P_W-1:0];

endmodule

// File: rtl/kaipokrandt_ir_queue.sv
// DEPTH-entry instruction FIFO with valid/ready on both sides and single-cycle flush.
// Define KAIPOKRANDT_IR_QUEUE_BYPASS_EN to let an empty queue forward bus_in in the same cycle.
module kaipokrandt_ir_queue
  import kaipokrandt_ir_pkg::*;
#(
  parameter int IR_W  = IR_W_DEF,
  parameter int OPC_W = OPC_W_DEF,
  parameter int P_W   = P_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IR_W-1:0]            bus_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IR_W-1:0]            ir_out,
  output logic [OPC_W-1:0]           opcode,
  output logic [P_W-1:0]             param1,
  output logic [P_W-1:0]             param2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  if ((OPC_W + 2 * P_W) != IR_W || !is_pow2(DEPTH) || DEPTH < 2 || DEPTH > 16 || !WIDTHS_OK)
  begin : g_param_err
    $error("kaipokrandt_ir_queue: need OPC_W+2*P_W==IR_W and DEPTH a power of two in 2..16");
  end

  logic [IR_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic             empty;
  logic             push;
  logic             write_en;
  logic             pop;
  logic             bypass_take;
  logic             head_valid;
  logic [IR_W-1:0]  head_word;

  assign empty    = (count_reg == '0);
  assign in_ready = (count_reg != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = !empty && out_ready && !flush;

`ifdef KAIPOKRANDT_IR_QUEUE_BYPASS_EN
  logic bypass_hit;
  // An empty queue presents bus_in directly; if consumed, it never touches storage.
  assign bypass_hit  = empty && in_valid && !flush;
  assign bypass_take = bypass_hit && out_ready;
  assign head_valid  = !empty || bypass_hit;
  assign head_word   = empty ? bus_in : mem[rd_ptr_reg];
`else
  assign bypass_take = 1'b0;
  assign head_valid  = !empty;
  assign head_word   = mem[rd_ptr_reg];
`endif

  assign write_en  = push && !bypass_take;
  assign out_valid = head_valid;
  assign count     = count_reg;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (write_en) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)      rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({write_en, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (write_en && !reset) mem[wr_ptr_reg] <= bus_in;
  end

  kaipokrandt_ir_fields #(
    .IR_W  (IR_W),
    .OPC_W (OPC_W),
    .P_W   (P_W)
  ) u_fields (
    .valid  (head_valid),
    .word   (head_word),
    .ir_out (ir_out),
    .opcode (opcode),
    .param1 (param1),
    .param2 (param2)
  );

endmodule

// File: tb/tb_kaipokrandt_ir_queue.sv
// Directed bench for the instruction queue: reset, push/pop order, full, streaming, flush, bypass.
module tb_kaipokrandt_ir_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bus_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ir_out;
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [5:0]  param2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kaipokrandt_ir_queue #(.IR_W(16), .OPC_W(4), .P_W(6), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bus_in    (bus_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ir_out    (ir_out),
    .opcode    (opcode),
    .param1    (param1),
    .param2    (param2),
    .count     (count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bus_in = 16'h0000;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_flags got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (ir_out !== 16'h0 || opcode !== 4'h0) begin
      n_fail++; $display("FAIL reset_ir got ir_out=%h opcode=%h want 0/0", ir_out, opcode);
    end
    $display("reset: count=%0d out_valid=%b in_ready=%b", count, out_valid, in_ready);
  endtask

  task automatic test_single_push();
    bus_in = 16'hA1C3; in_valid = 1'b1;
    #1;
`ifndef KAIPOKRANDT_IR_QUEUE_BYPASS_EN
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL push_latency got out_valid=%b want 0", out_valid); end
`endif
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || count !== 3'd1) begin
      n_fail++; $display("FAIL push_one got out_valid=%b count=%0d want 1/1", out_valid, count);
    end
    n_checks++;
    if (opcode !== 4'hA || param1 !== 6'h07 || param2 !== 6'h03) begin
      n_fail++; $display("FAIL push_fields got %h/%h/%h want a/07/03", opcode, param1, param2);
    end
    $display("push A1C3: opcode=%h param1=%h param2=%h count=%0d", opcode, param1, param2, count);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || ir_out !== 16'h0) begin
      n_fail++; $display("FAIL pop_one got count=%0d ir_out=%h want 0/0000", count, ir_out);
    end
  endtask

  task automatic test_fill();
    logic [15:0] words [4];
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
    for (int i = 0; i < 4; i++) begin
      bus_in = words[i]; in_valid = 1'b1;
      tick();
    end
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full got count=%0d in_ready=%b want 4/0", count, in_ready);
    end
    bus_in = 16'h5555; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4) begin n_fail++; $display("FAIL fill_overflow got count=%0d want 4", count); end
    $display("fill: count=%0d in_ready=%b", count, in_ready);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (ir_out !== words[i]) begin
        n_fail++; $display("FAIL fill_order[%0d] got %h want %h", i, ir_out, words[i]);
      end
      $display("pop %0d: ir_out=%h", i, ir_out);
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_drain got count=%0d out_valid=%b want 0/0", count, out_valid);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 2; k++) begin
      bus_in = 16'h0100 + 16'(k); in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      bus_in = 16'h0100 + 16'(j + 2); in_valid = 1'b1;
      n_checks++;
      if (ir_out !== 16'h0100 + 16'(j) || count !== 3'd2) begin
        n_fail++; $display("FAIL stream[%0d] got ir_out=%h count=%0d want %h/2", j, ir_out, count, 16'h0100 + 16'(j));
      end
      $display("stream %0d: ir_out=%h count=%0d", j, ir_out, count);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (ir_out !== 16'h010A || count !== 3'd2) begin
      n_fail++; $display("FAIL stream_end got ir_out=%h count=%0d want 010a/2", ir_out, count);
    end
  endtask

  task automatic test_flush();
    bus_in = 16'h0777; in_valid = 1'b1;
    tick();
    n_checks++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre got count=%0d want 3", count); end
    flush = 1'b1; bus_in = 16'hDEAD; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    idle_inputs();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || ir_out !== 16'h0) begin
      n_fail++; $display("FAIL flush got count=%0d out_valid=%b ir_out=%h want 0/0/0000", count, out_valid, ir_out);
    end
    $display("flush: count=%0d out_valid=%b ir_out=%h", count, out_valid, ir_out);
    bus_in = 16'hBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (ir_out !== 16'hBEEF || count !== 3'd1) begin
      n_fail++; $display("FAIL flush_after got ir_out=%h count=%0d want beef/1", ir_out, count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_in = 16'h0AAA; in_valid = 1'b1; tick();
    bus_in = 16'h0BBB; tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd2) begin n_fail++; $display("FAIL rstmid_pre got count=%0d want 2", count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid got count=%0d in_ready=%b out_valid=%b want 0/1/0", count, in_ready, out_valid);
    end
    bus_in = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (ir_out !== 16'h1234 || count !== 3'd1) begin
      n_fail++; $display("FAIL rstmid_push got ir_out=%h count=%0d want 1234/1", ir_out, count);
    end
    $display("reset mid-op then push: ir_out=%h count=%0d", ir_out, count);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_pop got count=%0d want 0", count); end
  endtask

`ifdef KAIPOKRANDT_IR_QUEUE_BYPASS_EN
  task automatic test_bypass();
    bus_in = 16'hF000; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || opcode !== 4'hF) begin
      n_fail++; $display("FAIL bypass_same got out_valid=%b opcode=%h want 1/f", out_valid, opcode);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bypass_consumed got count=%0d out_valid=%b want 0/0", count, out_valid);
    end
    $display("bypass F000: count=%0d", count);
    flush = 1'b1; bus_in = 16'hC001; in_valid = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_flush got out_valid=%b want 0", out_valid); end
    flush = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd1 || ir_out !== 16'hC001) begin
      n_fail++; $display("FAIL bypass_hold got count=%0d ir_out=%h want 1/c001", count, ir_out);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_push();
    test_fill();
    test_stream();
    test_flush();
    test_reset_mid();
`ifdef KAIPOKRANDT_IR_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kaipokrandt_ir_queue.md
# kaipokrandt_ir_queue

Parametrised instruction register successor: a DEPTH-entry FIFO that captures instruction words from the system bus with a valid/ready handshake and presents the oldest word, pre-split into opcode | param1 | param2, to the control unit. Lets fetch run ahead of execute and supports a single-cycle flush for branches. Sits between the bus interface and the control FSM, replacing the single-word instruction register.

## Interface
- IR_W, 16: instruction width; must equal OPC_W + 2*P_W
- OPC_W, 4: opcode field width (MSBs)
- P_W, 6: width of each of param1, param2
- DEPTH, 4: entries; power of two, 2..16
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all entries
- in_valid  in  1  bus_in holds an instruction
- in_ready  out  1  queue accepts a word this cycle
- bus_in  in  IR_W  instruction from system bus
- out_valid  out  1  head entry present
- out_ready  in  1  control unit consumes head
- ir_out  out  IR_W  head instruction
- opcode  out  OPC_W  ir_out[IR_W-1 -: OPC_W]
- param1  out  P_W  ir_out[2*P_W-1 -: P_W]
- param2  out  P_W  ir_out[P_W-1:0]
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Push: in_valid && in_ready; word written at wr_ptr, wr_ptr+1.
- Pop: out_valid && out_ready; rd_ptr+1.
- in_ready = (count != DEPTH); no push-through-full, even with simultaneous pop.
- out_valid = (count != 0); out_ready while empty ignored.
- Simultaneous push and pop (non-full, non-empty): count unchanged, both pointers advance.
- Pointers log2(DEPTH) bits, wrap modulo DEPTH naturally.
- flush: next cycle count=0, pointers=0; flush beats push and pop in same cycle (pushed word dropped, pop ignored).
- ir_out/opcode/param1/param2 show head entry when out_valid, else all zero.
- Storage not reset; only pointers/count reset.

## Timing
- Reset (sync, clk edge with reset=1): count=0, out_valid=0, in_ready=1, ir_out/fields=0, pointers=0. reset beats flush.
- Reset mid-operation: all entries lost, same values as above next cycle.
- Push-to-out_valid latency: 1 cycle (word pushed at edge N visible after edge N).
- Pop effect: next head visible after the consuming edge.
- in_ready and out_valid depend only on registered count (no combinational in->out path, except under bypass macro).
- Field outputs combinational from head register/mux.

## Configuration
- KAIPOKRANDT_IR_QUEUE_BYPASS_EN defined: when count==0 and in_valid, out_valid=1 and ir_out/fields=bus_in same cycle; if out_ready also 1, word consumed without being written (count stays 0); if out_ready=0, word written normally. flush still suppresses bypass (out_valid=0 while flush=1).
- Undefined: strict 1-cycle latency as in Timing; no combinational bus_in→ir_out path.

## Structure
- Package kaipokrandt_ir_pkg: default IR_W/OPC_W/P_W constants, opcode enum (4-bit), static width-check localparam.
- Sub-module kaipokrandt_ir_fields: combinational split of an IR_W word into opcode/param1/param2 (zero when valid=0); instantiated on head output.
- Elaboration-time check: error if OPC_W+2*P_W != IR_W or DEPTH not power of two.

## Test plan
- Reset, then push 16'hA1C3 -> next cycle out_valid=1, opcode=4'hA, param1=6'h07, param2=6'h03, count=1.
- Push 4 words, out_ready=0 -> count=4, in_ready=0; 5th push with in_valid=1 not accepted; pop order matches push order.
- Continuous push+pop for 10 cycles starting count=2 -> count stays 2, pointers wrap past DEPTH, data order preserved.
- count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, ir_out=0, pushed word absent.
- count=2, reset=1 for one cycle -> count=0, in_ready=1, out_valid=0; subsequent push 16'h1234 appears alone.
- Bypass build, empty, in_valid=1, out_ready=1, bus_in=16'hF000 -> same-cycle opcode=4'hF, out_valid=1; next cycle count=0.
